// File: rtl/tpu_pkg.sv
// Shared TPU definitions: weight-memory widths and the weight_loader state type.
package tpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } weight_loader_state_t;

  // Width of a counter spanning 0..n2-1, never narrower than one bit.
  function automatic int cnt_width(input int n2);
    return (n2 > 1) ? $clog2(n2) : 1;
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Host-side byte stream plus weight-memory write port of the weight loader.
//
// Handshake: in_data transfers on a rising edge where in_valid && in_ready.
// in_ready never depends on in_valid; the source may hold in_valid low for
// any number of cycles. wr_en is a plain one-cycle write strobe with no
// back-pressure: the memory takes wr_addr/wr_data on every edge wr_en is high.
interface weight_loader_if #(
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int ADDR_W = tpu_pkg::ADDR_W
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, base_addr, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/weight_xpose_buf.sv
// N x N weight staging buffer: filled in row-major order, read in column-major
// order, so reading index i returns W[i%N][i/N] (the transpose).
module weight_xpose_buf #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int CW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [CW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  localparam int NN = N * N;

  logic [DATA_W-1:0] mem [NN];
  logic [CW-1:0]     rd_pos;

  // Store byte k of the stream at flat position k (row k/N, column k%N).
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Column-major index i maps to row i%N, column i/N of the stored matrix.
  always_comb begin
    rd_pos  = '0;
    rd_pos  = CW'((int'(rd_idx) % N) * N + int'(rd_idx) / N);
    rd_data = mem[rd_pos];
  end
endmodule

// File: rtl/weight_loader.sv
// Weight-memory writer: buffers an N x N row-major weight stream, then writes
// it out one element per cycle in column-major order from a latched base.
module weight_loader
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int ADDR_W = tpu_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  weight_loader_if.slave       bus,
  output weight_loader_state_t state_dbg
);
  localparam int            NN   = N * N;
  localparam int            CW   = cnt_width(NN);
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  weight_loader_state_t state;
  logic [CW-1:0]        cnt;
  logic [ADDR_W-1:0]    base_q;
  logic                 in_ready_q;
  logic                 wr_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 buf_we;
  logic [DATA_W-1:0]    buf_rd;

  // in_ready_q is high only in LOAD, so this is exactly a LOAD-state transfer.
  assign buf_we = in_ready_q && bus.in_valid;

  weight_xpose_buf #(
    .N      (N),
    .DATA_W (DATA_W),
    .CW     (CW)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (cnt),
    .wr_data (bus.in_data),
    .rd_idx  (cnt),
    .rd_data (buf_rd)
  );

  // Control FSM: one counter serves as byte index in LOAD and write index in WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      base_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q     <= bus.base_addr;
            cnt        <= '0;
            state      <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            if (cnt == LAST) begin
              cnt        <= '0;
              state      <= WRITE;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            state   <= DONE;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Address and data are forced to zero outside WRITE; the address wraps modulo 2^ADDR_W.
  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_en_q ? (base_q + ADDR_W'(cnt)) : '0;
  assign bus.wr_data  = wr_en_q ? buf_rd : '0;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign state_dbg    = state;
endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with N=2 and N=3 instances, checked against
// a transpose/schedule model computed from the stream and base address.
module tb_weight_loader;
  import tpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  weight_loader_if #(.DATA_W(8), .ADDR_W(13)) b2 ();
  weight_loader_if #(.DATA_W(8), .ADDR_W(13)) b3 ();
  weight_loader_state_t sd2, sd3;

  weight_loader #(.N(2), .DATA_W(8), .ADDR_W(13)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .state_dbg(sd2));
  weight_loader #(.N(3), .DATA_W(8), .ADDR_W(13)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .state_dbg(sd3));

  int          sel = 2;
  logic        start_v = 1'b0;
  logic [12:0] base_v = '0;
  logic        in_valid_v = 1'b0;
  logic [7:0]  in_data_v = '0;

  assign b2.start     = (sel == 2) ? start_v : 1'b0;
  assign b2.base_addr = base_v;
  assign b2.in_valid  = (sel == 2) ? in_valid_v : 1'b0;
  assign b2.in_data   = in_data_v;
  assign b3.start     = (sel == 3) ? start_v : 1'b0;
  assign b3.base_addr = base_v;
  assign b3.in_valid  = (sel == 3) ? in_valid_v : 1'b0;
  assign b3.in_data   = in_data_v;

  logic                 in_ready_s, wr_en_s, busy_s, done_s;
  logic [12:0]          wr_addr_s;
  logic [7:0]           wr_data_s;
  weight_loader_state_t state_s;
  assign in_ready_s = (sel == 2) ? b2.in_ready : b3.in_ready;
  assign wr_en_s    = (sel == 2) ? b2.wr_en    : b3.wr_en;
  assign wr_addr_s  = (sel == 2) ? b2.wr_addr  : b3.wr_addr;
  assign wr_data_s  = (sel == 2) ? b2.wr_data  : b3.wr_data;
  assign busy_s     = (sel == 2) ? b2.busy     : b3.busy;
  assign done_s     = (sel == 2) ? b2.done     : b3.done;
  assign state_s    = (sel == 2) ? sd2         : sd3;

  // ---------------- scoreboard ----------------
  // Entry: {edge at which the write is taken (32), addr (13), data (8)}
  logic [52:0] exp_q2[$];
  logic [52:0] exp_q3[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk_en = 1'b0;
  logic [7:0]  pat [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: write i goes to base+i (13-bit wrap) with W[i%n][i/n].
  function automatic logic [20:0] model_entry(input logic [12:0] base, input int n, input int i);
    logic [12:0] a;
    a = base + 13'(i);
    return {a, pat[(i % n) * n + i / n]};
  endfunction

  // Edges from the accepted start to the done pulse.
  function automatic int done_rel(input int n, input int gaps);
    return 2 * n * n + 1 + gaps;
  endfunction

  task automatic cmp_write(input int d, input logic en, input logic [12:0] a, input logic [7:0] dt);
    logic [52:0] e;
    string p;
    p = (d == 2) ? "u2" : "u3";
    if (en) begin
      if (((d == 2) ? exp_q2.size() : exp_q3.size()) == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_wr_unexpected actual wr_en=1 addr=%0h data=%0h required wr_en=0 (t=%0t)", p, a, dt, $time);
      end else begin
        e = (d == 2) ? exp_q2.pop_front() : exp_q3.pop_front();
        chk({p, "_wr_edge"}, 64'(cyc + 1), 64'(e[52:21]));
        chk({p, "_wr_addr"}, 64'(a), 64'(e[20:8]));
        chk({p, "_wr_data"}, 64'(dt), 64'(e[7:0]));
      end
    end else begin
      chk({p, "_addr_idle"}, 64'(a), 64'd0);
      chk({p, "_data_idle"}, 64'(dt), 64'd0);
    end
  endtask

  // Compare process: every cycle, both instances' write ports against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_write(2, b2.wr_en, b2.wr_addr, b2.wr_data);
      cmp_write(3, b3.wr_en, b3.wr_addr, b3.wr_data);
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, 64'(in_ready_s), 64'd0);
    chk({nm, "_wr_en"},    64'(wr_en_s),    64'd0);
    chk({nm, "_wr_addr"},  64'(wr_addr_s),  64'd0);
    chk({nm, "_wr_data"},  64'(wr_data_s),  64'd0);
    chk({nm, "_busy"},     64'(busy_s),     64'd0);
    chk({nm, "_done"},     64'(done_s),     64'd0);
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input int d, input logic [12:0] base, input int gap_at,
                        input int gap_len, input bit noise, input int abort_after);
    int  t;
    int  n;
    bit  got;
    sel = d;
    n   = d;
    if (noise) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        in_valid_v = 1'b1;
        in_data_v  = 8'hAA;
        chk("idle_in_ready", 64'(in_ready_s), 64'd0);
      end
    end
    @(negedge clk);
    t          = cyc + 1;
    start_v    = 1'b1;
    base_v     = base;
    in_valid_v = noise;
    in_data_v  = 8'hAA;
    if (abort_after < 0) begin
      for (int i = 0; i < n * n; i++) begin
        if (d == 2) exp_q2.push_back({32'(t + n * n + gap_len + 1 + i), model_entry(base, n, i)});
        else        exp_q3.push_back({32'(t + n * n + gap_len + 1 + i), model_entry(base, n, i)});
      end
    end
    for (int k = 0; k < n * n; k++) begin
      if (k == abort_after) begin
        @(negedge clk);
        start_v    = 1'b0;
        in_valid_v = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        chk("rst_mid_state", 64'(state_s), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          start_v    = noise;
          base_v     = noise ? 13'h0AA : base;
          in_valid_v = 1'b0;
          chk("gap_in_ready", 64'(in_ready_s), 64'd1);
        end
      end
      @(negedge clk);
      start_v    = noise;
      base_v     = noise ? 13'h0AA : base;
      in_valid_v = 1'b1;
      in_data_v  = pat[k];
      chk("load_in_ready", 64'(in_ready_s), 64'd1);
    end
    @(negedge clk);
    in_valid_v = noise;
    in_data_v  = 8'hAA;
    got = 1'b0;
    for (int w = 0; w < 60 && !got; w++) begin
      if (w > 0) @(negedge clk);
      start_v = noise;
      if (done_s) begin
        got = 1'b1;
        chk("done_edge", 64'(cyc + 1), 64'(t + done_rel(n, gap_len)));
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    start_v    = 1'b0;
    in_valid_v = 1'b0;
    chk("done_pulse_len", 64'(done_s), 64'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("after_busy", 64'(busy_s), 64'd0);
      chk("after_in_ready", 64'(in_ready_s), 64'd0);
      chk("after_state", 64'(state_s), 64'(IDLE));
    end
    chk("writes_drained", 64'((d == 2) ? exp_q2.size() : exp_q3.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    sel = 2;
    chk_all_zero("reset_u2");
    sel = 3;
    chk_all_zero("reset_u3");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Basic: base 0x00F, 3,4,5,6 -> (00F,3) (010,5) (011,4) (012,6), done at t+9
    pat = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    chk("pin_basic0", 64'(model_entry(13'h00F, 2, 0)), 64'({13'h00F, 8'd3}));
    chk("pin_basic1", 64'(model_entry(13'h00F, 2, 1)), 64'({13'h010, 8'd5}));
    chk("pin_basic2", 64'(model_entry(13'h00F, 2, 2)), 64'({13'h011, 8'd4}));
    chk("pin_basic3", 64'(model_entry(13'h00F, 2, 3)), 64'({13'h012, 8'd6}));
    chk("pin_done_n2", 64'(done_rel(2, 0)), 64'd9);
    run_op(2, 13'h00F, -1, 0, 1'b0, -1);

    // Backpressure: two idle cycles between bytes 2 and 3
    chk("pin_done_gap", 64'(done_rel(2, 2)), 64'd11);
    run_op(2, 13'h00F, 2, 2, 1'b0, -1);

    // Address wrap
    pat = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    chk("pin_wrap2", 64'(model_entry(13'h1FFE, 2, 2)), 64'({13'h0000, 8'd2}));
    chk("pin_wrap3", 64'(model_entry(13'h1FFE, 2, 3)), 64'({13'h0001, 8'd4}));
    run_op(2, 13'h1FFE, -1, 0, 1'b0, -1);

    // Reset after two accepted bytes, then a fresh load
    pat = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_op(2, 13'h040, -1, 0, 1'b0, 2);
    repeat (2) @(negedge clk);
    chk("rst_no_writes", 64'(exp_q2.size()), 64'd0);
    pat = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    chk("pin_rst1", 64'(model_entry(13'h100, 2, 1)), 64'({13'h101, 8'd9}));
    run_op(2, 13'h100, -1, 0, 1'b0, -1);

    // Ignored inputs: in_valid in IDLE, start during LOAD/WRITE/DONE
    pat = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_op(2, 13'h020, -1, 0, 1'b1, -1);

    // N=3: base 0, 1..9 -> 1,4,7,2,5,8,3,6,9 at 0..8, done at t+19
    pat = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    chk("pin_n3_1", 64'(model_entry(13'h000, 3, 1)), 64'({13'h001, 8'd4}));
    chk("pin_n3_5", 64'(model_entry(13'h000, 3, 5)), 64'({13'h005, 8'd8}));
    chk("pin_n3_8", 64'(model_entry(13'h000, 3, 8)), 64'({13'h008, 8'd9}));
    chk("pin_done_n3", 64'(done_rel(3, 0)), 64'd19);
    run_op(3, 13'h000, -1, 0, 1'b0, -1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
# weight_loader

Writer side of the weight memory: accepts a square weight matrix as a row-major byte stream, holds it in an internal buffer, then issues one write per cycle into the weight memory in transposed (column-major) order starting at a programmed base address. It sits between the host/instruction path and the weight memory's write port. The combinational 4-weight read port of the weight memory therefore sees the layout the systolic array expects.

## Interface

Parameters:
- `N`, 2: matrix dimension. The matrix is N×N; N ≥ 1.
- `DATA_W`, 8: weight width in bits.
- `ADDR_W`, 13: weight-memory address width in bits.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  single-cycle request to load a matrix; honored only in IDLE.
- `base_addr`  in  ADDR_W  first write address; sampled on an accepted `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `in_data`  in  DATA_W  weight byte, row-major order (W[0][0], W[0][1], …).
- `wr_en`  out  1  weight-memory write strobe.
- `wr_addr`  out  ADDR_W  weight-memory write address.
- `wr_data`  out  DATA_W  weight-memory write data.
- `busy`  out  1  high in LOAD and WRITE.
- `done`  out  1  one-cycle completion pulse.

## Operation

- States are IDLE, LOAD, WRITE and DONE.
- **IDLE**
  - `in_ready` is 0.
  - On `start`, latch `base_addr`, clear the element counter and go to LOAD.
  - `in_valid` is ignored in IDLE.
- **LOAD**
  - `in_ready` is 1.
  - A byte transfers when `in_valid && in_ready`.
  - Byte k (0..N²−1) is stored as W[k/N][k%N].
  - The N²-th transfer clears the counter and moves to WRITE on the next edge.
  - No transfer means the state holds, with unlimited gaps allowed.
- **WRITE**
  - `in_ready` is 0 and `wr_en` is 1 for exactly N² consecutive cycles, with i = 0..N²−1.
  - `wr_addr` = (base + i) mod 2^ADDR_W. The address wraps silently.
  - `wr_data` = W[i%N][i/N], i.e. column-major, which is the transpose of the input.
  - After i = N²−1, go to DONE.
- **DONE**
  - `done` is 1 for one cycle, then return to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- All outputs are decoded from registered state, counter and buffer only. There is no combinational input-to-output path.
- Reset value of every output is 0: `in_ready`, `wr_en`, `wr_addr`, `wr_data`, `busy` and `done`.
- In reset, the state goes to IDLE and the counter to 0. Buffer contents are don't-care.
- Reset asserted mid-LOAD or mid-WRITE:
  - abandons the operation;
  - leaves no further `wr_en` from the cycle after reset is sampled;
  - causes partial data to be discarded.
- Outside WRITE, `wr_addr` and `wr_data` are 0.

## Timing

- Cycle numbering, with `start` accepted at edge t:
  - LOAD is in effect from cycle t+1.
  - With continuous `in_valid`, bytes transfer at cycles t+1..t+N².
  - WRITE occupies cycles t+N²+1..t+2N².
  - `done` is high at t+2N²+1.
  - IDLE resumes at t+2N²+2; a new `start` is honored from that cycle.
- Each cycle of `in_valid` gap adds exactly one cycle to the schedule.
- Throughput is one byte in per cycle and one write out per cycle.

## Structure

- Shared package `tpu_pkg` holds:
  - the `weight_loader_state_t` enum (IDLE, LOAD, WRITE, DONE);
  - the `DATA_W` and `ADDR_W` constants shared with the weight memory.
- The counter width is $clog2(N*N) bits, derived locally.
- One natural sub-module is `weight_xpose_buf`. It is an N×N register array with a row-major write index and a column-major read index. The FSM and address generation stay in `weight_loader`.

## Test plan

- **Basic:** N=2, base 0x00F, stream 3,4,5,6 back-to-back. Required writes are (0x00F,3), (0x010,5), (0x011,4), (0x012,6) in cycles t+5..t+8, with `done` at t+9.
- **Backpressure:** same data with `in_valid` low for 2 cycles between bytes 2 and 3. The writes are identical, everything shifts by 2 cycles, and `in_ready` stays 1 throughout LOAD.
- **Wrap:** base 0x1FFE with 1,2,3,4. Required writes are addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 with data 1,3,2,4.
- **Reset mid-operation:** `rst_n` low after 2 bytes accepted. The next cycle has all outputs 0 and no `wr_en`. A fresh `start` with 7,8,9,10 then writes 7,9,8,10.
- **Ignored inputs:** `in_valid` high in IDLE is not accepted, and `start` pulsed during LOAD and WRITE has no effect. After `done`, the block is back in IDLE with no second load started.
- **Parameterisation:** N=3, base 0, stream 1..9. Required writes are 1,4,7,2,5,8,3,6,9 at addresses 0..8, with `done` at t+19.
